renode_apb3_arbiter: RTL and testbench

- Shares one downstream APB3 completer between NumRequesters upstream APB3 requesters.
- Sits between several requester-side bus ports and a single completer, for example one renode_apb3_completer bridge into Renode.
- Grants one requester at a time using round-robin arbitration.
- Replays the granted transfer downstream as a full SETUP/ACCESS sequence, then routes the response back to the granted requester.

---
 rtl/renode_apb3_pkg.sv | 7 +
 rtl/renode_rr_arbiter.sv | 36 +++
 rtl/renode_apb3_arbiter.sv | 94 +++++++++
 tb/tb_renode_apb3_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/renode_apb3_pkg.sv
// renode_apb3_pkg: shared state and grant-vector types for the APB3 arbiter
// and its round-robin picker.
package renode_apb3_pkg;
  localparam int unsigned MaxRequesters = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_t;
  typedef logic [MaxRequesters-1:0] grant_vec_t;
endpackage

// File: rtl/renode_rr_arbiter.sv
// renode_rr_arbiter: combinational round-robin pick with a last-grant pointer
// that only advances when the owner's transfer is accepted.
module renode_rr_arbiter
  import renode_apb3_pkg::*;
#(
  parameter int unsigned NumRequesters = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumRequesters-1:0] req_i,
  input  logic                     accept_i,
  input  logic [NumRequesters-1:0] accept_gnt_i,
  output logic [NumRequesters-1:0] gnt_o
);
  localparam int unsigned PtrWidth = $clog2(NumRequesters);
  logic [PtrWidth-1:0] ptr_q, ptr_d;
  grant_vec_t pick;
  // Lowest request above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    pick = '0;
    for (int i = int'(NumRequesters) - 1; i >= 0; i--)
      if (req_i[i]) pick = grant_vec_t'(1) << i;
    for (int i = int'(NumRequesters) - 1; i >= 0; i--)
      if (req_i[i] && i > int'(ptr_q)) pick = grant_vec_t'(1) << i;
  end
  assign gnt_o = pick[NumRequesters-1:0];
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < int'(NumRequesters); i++)
      if (accept_i && accept_gnt_i[i]) ptr_d = PtrWidth'(i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= PtrWidth'(NumRequesters - 1);
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/renode_apb3_arbiter.sv
// renode_apb3_arbiter: shares one APB3 completer among several requesters,
// replaying the round-robin winner's transfer as a fresh SETUP/ACCESS pair.
module renode_apb3_arbiter
  import renode_apb3_pkg::*;
#(
  parameter int unsigned NumRequesters = 2,
  parameter int unsigned AddressWidth  = 20,
  parameter int unsigned DataWidth     = 32
) (
  input  logic                               pclk,
  input  logic                               presetn,
  input  logic [NumRequesters-1:0]           s_psel,
  input  logic [NumRequesters-1:0]           s_penable,
  input  logic [NumRequesters-1:0]           s_pwrite,
  input  logic [NumRequesters*AddressWidth-1:0] s_paddr,
  input  logic [NumRequesters*DataWidth-1:0] s_pwdata,
  output logic [NumRequesters-1:0]           s_pready,
  output logic [DataWidth-1:0]               s_prdata,
  output logic [NumRequesters-1:0]           s_pslverr,
  output logic                               m_psel,
  output logic                               m_penable,
  output logic                               m_pwrite,
  output logic [AddressWidth-1:0]            m_paddr,
  output logic [DataWidth-1:0]               m_pwdata,
  input  logic                               m_pready,
  input  logic [DataWidth-1:0]               m_prdata,
  input  logic                               m_pslverr,
  output logic [NumRequesters-1:0]           grant
);
  arb_state_t state_q, state_d;
  logic [NumRequesters-1:0] grant_q, grant_d, pick;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic write_q, write_d;
  logic busy, done;
  logic unused_penable;
  assign unused_penable = |s_penable;
  assign busy = state_q != IDLE;
  assign done = state_q == ACCESS && m_pready;
  renode_rr_arbiter #(.NumRequesters(NumRequesters)) u_rr (
    .clk_i       (pclk),
    .rst_ni      (presetn),
    .req_i       (s_psel),
    .accept_i    (done),
    .accept_gnt_i(grant_q),
    .gnt_o       (pick)
  );
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (|s_psel ? SETUP : IDLE) :
              state_q == SETUP ? ACCESS : (m_pready ? IDLE : ACCESS);
  end
  // Winner's request is captured in IDLE so later upstream changes cannot disturb it.
  always_comb begin
    grant_d = done ? '0 : grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (state_q == IDLE) begin
      grant_d = pick;
      for (int i = 0; i < int'(NumRequesters); i++)
        if (pick[i]) begin
          addr_d  = s_paddr[i*AddressWidth +: AddressWidth];
          wdata_d = s_pwdata[i*DataWidth +: DataWidth];
          write_d = s_pwrite[i];
        end
    end
  end
  always_comb begin
    m_psel    = busy;
    m_penable = state_q == ACCESS;
    m_pwrite  = busy && write_q;
    m_paddr   = busy ? addr_q : '0;
    m_pwdata  = busy ? wdata_q : '0;
    s_pready  = done ? grant_q : '0;
    s_prdata  = done ? m_prdata : '0;
    s_pslverr = done && m_pslverr ? grant_q : '0;
    grant     = grant_q;
  end
endmodule

// File: tb/tb_renode_apb3_arbiter.sv
// tb_renode_apb3_arbiter: directed vector table plus hand sequences for
// wait states, asynchronous reset and three-way fairness.
module tb_renode_apb3_arbiter;
  localparam int N = 3, AW = 20, DW = 32;
  logic pclk = 1'b0, presetn = 1'b0;
  logic [N-1:0] s_psel = '0, s_penable = '0, s_pwrite = '0, s_pready, s_pslverr, grant;
  logic [N*AW-1:0] s_paddr = '0;
  logic [N*DW-1:0] s_pwdata = '0;
  logic [DW-1:0] s_prdata, m_pwdata, m_prdata = '0;
  logic [AW-1:0] m_paddr;
  logic m_psel, m_penable, m_pwrite, m_pready = 1'b0, m_pslverr = 1'b0;
  int total = 0, bad = 0;
  always #5 pclk = ~pclk;
  renode_apb3_arbiter #(.NumRequesters(N), .AddressWidth(AW), .DataWidth(DW)) dut (
    .pclk(pclk), .presetn(presetn), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pready(s_pready),
    .s_prdata(s_prdata), .s_pslverr(s_pslverr), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pready(m_pready),
    .m_prdata(m_prdata), .m_pslverr(m_pslverr), .grant(grant)
  );
  typedef struct {
    logic [N-1:0] psel, pwrite;
    logic [N*AW-1:0] paddr;
    logic [N*DW-1:0] pwdata;
    logic mrdy, mslv;
    logic [DW-1:0] mrdata;
    logic [N-1:0] grant;
    logic mpsel, mpen, mpwr;
    logic [AW-1:0] mpaddr;
    logic [DW-1:0] mpwdata;
    logic [N-1:0] spr, sslv;
    logic [DW-1:0] sprdata;
  } vec_t;
  vec_t v[15];
  function automatic vec_t mk(input logic [N-1:0] psel, pwrite, input logic [N*AW-1:0] paddr,
      input logic [N*DW-1:0] pwdata, input logic mrdy, mslv, input logic [DW-1:0] mrdata,
      input logic [N-1:0] g, input logic mpsel, mpen, mpwr, input logic [AW-1:0] mpaddr,
      input logic [DW-1:0] mpwdata, input logic [N-1:0] spr, sslv, input logic [DW-1:0] sprdata);
    vec_t r;
    r.psel = psel; r.pwrite = pwrite; r.paddr = paddr; r.pwdata = pwdata;
    r.mrdy = mrdy; r.mslv = mslv; r.mrdata = mrdata; r.grant = g;
    r.mpsel = mpsel; r.mpen = mpen; r.mpwr = mpwr; r.mpaddr = mpaddr;
    r.mpwdata = mpwdata; r.spr = spr; r.sslv = sslv; r.sprdata = sprdata;
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, " grant"}, 64'(grant), 64'd0);
    check({tag, " m_psel"}, 64'(m_psel), 64'd0);
    check({tag, " m_penable"}, 64'(m_penable), 64'd0);
    check({tag, " m_paddr"}, 64'(m_paddr), 64'd0);
    check({tag, " m_pwdata"}, 64'(m_pwdata), 64'd0);
    check({tag, " s_pready"}, 64'(s_pready), 64'd0);
    check({tag, " s_prdata"}, 64'(s_prdata), 64'd0);
    check({tag, " s_pslverr"}, 64'(s_pslverr), 64'd0);
  endtask
  initial begin
    logic [N*AW-1:0] a2, a5, a1;
    logic [N*DW-1:0] w5, w1;
    a2 = {20'h0, 20'h20, 20'h10};
    a5 = {20'h0, 20'h30, 20'h0};
    a1 = {20'h0, 20'h0, 20'h00100};
    w5 = {32'h0, 32'h55, 32'h0};
    w1 = {32'h0, 32'h0, 32'hDEADBEEF};
    // simultaneous reads: r0 first, one IDLE bubble, then r1
    v[0]  = mk(3'b011, 3'b000, a2, '0, 1, 0, 32'h11, 3'b000, 0, 0, 0, 20'h0,  32'h0, 3'b000, 3'b000, 32'h0);
    v[1]  = mk(3'b011, 3'b000, a2, '0, 1, 0, 32'h11, 3'b001, 1, 0, 0, 20'h10, 32'h0, 3'b000, 3'b000, 32'h0);
    v[2]  = mk(3'b011, 3'b000, a2, '0, 1, 0, 32'h11, 3'b001, 1, 1, 0, 20'h10, 32'h0, 3'b001, 3'b000, 32'h11);
    v[3]  = mk(3'b010, 3'b000, a2, '0, 1, 0, 32'h22, 3'b000, 0, 0, 0, 20'h0,  32'h0, 3'b000, 3'b000, 32'h0);
    v[4]  = mk(3'b010, 3'b000, a2, '0, 1, 0, 32'h22, 3'b010, 1, 0, 0, 20'h20, 32'h0, 3'b000, 3'b000, 32'h0);
    v[5]  = mk(3'b010, 3'b000, a2, '0, 1, 0, 32'h22, 3'b010, 1, 1, 0, 20'h20, 32'h0, 3'b010, 3'b000, 32'h22);
    v[6]  = mk(3'b000, 3'b000, a2, '0, 1, 0, 32'h22, 3'b000, 0, 0, 0, 20'h0,  32'h0, 3'b000, 3'b000, 32'h0);
    // error routed only to r1, only in its completing cycle
    v[7]  = mk(3'b010, 3'b010, a5, w5, 1, 1, 32'h99, 3'b000, 0, 0, 0, 20'h0,  32'h0,  3'b000, 3'b000, 32'h0);
    v[8]  = mk(3'b010, 3'b010, a5, w5, 1, 1, 32'h99, 3'b010, 1, 0, 1, 20'h30, 32'h55, 3'b000, 3'b000, 32'h0);
    v[9]  = mk(3'b010, 3'b010, a5, w5, 1, 1, 32'h99, 3'b010, 1, 1, 1, 20'h30, 32'h55, 3'b010, 3'b010, 32'h99);
    v[10] = mk(3'b000, 3'b000, a5, w5, 1, 1, 32'h99, 3'b000, 0, 0, 0, 20'h0,  32'h0,  3'b000, 3'b000, 32'h0);
    // single write by r0
    v[11] = mk(3'b001, 3'b001, a1, w1, 1, 0, 32'h0, 3'b000, 0, 0, 0, 20'h0,     32'h0,        3'b000, 3'b000, 32'h0);
    v[12] = mk(3'b001, 3'b001, a1, w1, 1, 0, 32'h0, 3'b001, 1, 0, 1, 20'h00100, 32'hDEADBEEF, 3'b000, 3'b000, 32'h0);
    v[13] = mk(3'b001, 3'b001, a1, w1, 1, 0, 32'h0, 3'b001, 1, 1, 1, 20'h00100, 32'hDEADBEEF, 3'b001, 3'b000, 32'h0);
    v[14] = mk(3'b000, 3'b000, a1, w1, 1, 0, 32'h0, 3'b000, 0, 0, 0, 20'h0,     32'h0,        3'b000, 3'b000, 32'h0);
    #12;
    check_idle_outputs("reset");
    tick();
    presetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      s_psel = v[i].psel; s_penable = v[i].psel; s_pwrite = v[i].pwrite;
      s_paddr = v[i].paddr; s_pwdata = v[i].pwdata;
      m_pready = v[i].mrdy; m_pslverr = v[i].mslv; m_prdata = v[i].mrdata;
      @(negedge pclk);
      check($sformatf("v%0d grant", i), 64'(grant), 64'(v[i].grant));
      check($sformatf("v%0d m_psel", i), 64'(m_psel), 64'(v[i].mpsel));
      check($sformatf("v%0d m_penable", i), 64'(m_penable), 64'(v[i].mpen));
      check($sformatf("v%0d m_pwrite", i), 64'(m_pwrite), 64'(v[i].mpwr));
      check($sformatf("v%0d m_paddr", i), 64'(m_paddr), 64'(v[i].mpaddr));
      check($sformatf("v%0d m_pwdata", i), 64'(m_pwdata), 64'(v[i].mpwdata));
      check($sformatf("v%0d s_pready", i), 64'(s_pready), 64'(v[i].spr));
      check($sformatf("v%0d s_pslverr", i), 64'(s_pslverr), 64'(v[i].sslv));
      check($sformatf("v%0d s_prdata", i), 64'(s_prdata), 64'(v[i].sprdata));
    end
    // wait states: r2 write held in ACCESS for 4 cycles
    tick();
    s_psel = 3'b100; s_penable = 3'b100; s_pwrite = 3'b100;
    s_paddr = {20'h40, 20'h0, 20'h0}; s_pwdata = {32'hCAFE, 32'h0, 32'h0};
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'h0;
    @(negedge pclk);
    check("ws idle grant", 64'(grant), 64'd0);
    tick();
    @(negedge pclk);
    check("ws setup grant", 64'(grant), 64'b100);
    check("ws setup penable", 64'(m_penable), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge pclk);
      check($sformatf("ws%0d penable", c), 64'(m_penable), 64'd1);
      check($sformatf("ws%0d paddr", c), 64'(m_paddr), 64'h40);
      check($sformatf("ws%0d pwdata", c), 64'(m_pwdata), 64'hCAFE);
      check($sformatf("ws%0d pwrite", c), 64'(m_pwrite), 64'd1);
      check($sformatf("ws%0d s_pready", c), 64'(s_pready), 64'd0);
    end
    tick();
    m_pready = 1'b1;
    @(negedge pclk);
    check("ws done s_pready", 64'(s_pready), 64'b100);
    check("ws done paddr", 64'(m_paddr), 64'h40);
    tick();
    s_psel = '0; s_penable = '0; s_pwrite = '0;
    @(negedge pclk);
    check("ws after grant", 64'(grant), 64'd0);
    // reset dropped mid-ACCESS on an r1 read
    tick();
    s_psel = 3'b010; s_penable = 3'b010; s_paddr = {20'h0, 20'h50, 20'h0}; m_pready = 1'b0;
    @(negedge pclk);
    tick();
    @(negedge pclk);
    check("rst setup grant", 64'(grant), 64'b010);
    tick();
    @(negedge pclk);
    check("rst access penable", 64'(m_penable), 64'd1);
    #1;
    presetn = 1'b0;
    m_pready = 1'b1;
    s_psel = 3'b111; s_penable = 3'b111;
    #1;
    check_idle_outputs("async rst");
    tick();
    @(negedge pclk);
    check("rst held s_pready", 64'(s_pready), 64'd0);
    tick();
    presetn = 1'b1;
    // all three requesting continuously: strict 0,1,2 rotation
    for (int t = 0; t < 9; t++) begin
      m_prdata = 32'(t + 1);
      @(negedge pclk);
      check($sformatf("rr%0d idle grant", t), 64'(grant), 64'd0);
      tick();
      @(negedge pclk);
      check($sformatf("rr%0d grant", t), 64'(grant), 64'(1 << (t % 3)));
      tick();
      @(negedge pclk);
      check($sformatf("rr%0d s_pready", t), 64'(s_pready), 64'(1 << (t % 3)));
      check($sformatf("rr%0d s_prdata", t), 64'(s_prdata), 64'(t + 1));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
